// File: rtl/mode_select.sv
// Mode select front end: synchronises and debounces SW[1:0] and KEY1, then
// produces the registered 2-bit pattern select and a one-cycle change strobe.
module mode_select #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       ADC_CLK_10,
    input  logic       RESET_N,
    input  logic [1:0] SW,
    input  logic       KEY1,
    output logic [1:0] sel,
    output logic       sel_change
);

    localparam int unsigned      N_IN    = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Bit order {KEY1, SW[1], SW[0]}; the button idles high
    localparam logic [N_IN-1:0]  IN_RST  = 3'b100;

    logic [N_IN-1:0]  s1_q;
    logic [N_IN-1:0]  s2_q;
    logic [N_IN-1:0]  db_q;
    logic [N_IN-1:0]  db_d;
    logic [N_IN-1:0]  db_prev_q;
    logic [CNT_W-1:0] cnt_q [N_IN];
    logic [CNT_W-1:0] cnt_d [N_IN];
    logic [1:0]       sel_q;
    logic [1:0]       sel_d;
    logic             sel_change_q;
    logic             sel_change_d;
    logic             sw_evt_c;
    logic             key_evt_c;

    // Two-flop synchroniser per raw input
    always_ff @(posedge ADC_CLK_10 or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q <= IN_RST;
            s2_q <= IN_RST;
        end else begin
            s1_q <= {KEY1, SW};
            s2_q <= s1_q;
        end
    end

    // Per-input stability counters; any return to the debounced level restarts
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < int'(N_IN); i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge ADC_CLK_10 or negedge RESET_N) begin
        if (!RESET_N) begin
            db_q      <= IN_RST;
            db_prev_q <= IN_RST;
            for (int i = 0; i < int'(N_IN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int i = 0; i < int'(N_IN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Switch change loads the mode and overrides a simultaneous press
    always_comb begin
        sw_evt_c  = (db_q[1:0] != db_prev_q[1:0]);
        key_evt_c = db_prev_q[2] & ~db_q[2];
        sel_d     = sel_q;
        if (sw_evt_c) begin
            sel_d = db_q[1:0];
        end else if (key_evt_c) begin
            sel_d = sel_q + 2'd1;
        end
        sel_change_d = (sel_d != sel_q);
    end

    always_ff @(posedge ADC_CLK_10 or negedge RESET_N) begin
        if (!RESET_N) begin
            sel_q        <= 2'd0;
            sel_change_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            sel_change_q <= sel_change_d;
        end
    end

    assign sel        = sel_q;
    assign sel_change = sel_change_q;

endmodule

// File: tb/tb_mode_select.sv
// Scoreboard bench for mode_select: stimulus queues the expected mode value and
// pulse cycle; a negedge monitor checks every pulse and that sel holds otherwise.
module tb_mode_select;

    typedef struct {
        logic [1:0] val;
        int         cyc;
    } exp_t;

    // Raw change driven after edge k is first sampled at k+1; sel updates at k+7
    localparam int LAT = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sw;
    logic       key;
    logic [1:0] sel;
    logic       sel_change;

    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [1:0] cur_sel = 2'd0;
    exp_t       exp_q[$];

    mode_select #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .ADC_CLK_10(clk),
        .RESET_N   (rst_n),
        .SW        (sw),
        .KEY1      (key),
        .sel       (sel),
        .sel_change(sel_change)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_sel(input logic [1:0] v);
        exp_t e;
        e.val = v;
        e.cyc = cyc + LAT;
        exp_q.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cur_sel = 2'd0;
            check("reset_sel", int'(sel), 0);
            check("reset_sel_change", int'(sel_change), 0);
        end else if (sel_change) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", int'(sel), int'(cur_sel));
                cur_sel = sel;
            end else begin
                e = exp_q.pop_front();
                check("pulse_sel", int'(sel), int'(e.val));
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_changes_sel", int'(sel != cur_sel), 1);
                cur_sel = e.val;
            end
        end else begin
            check("sel_hold", int'(sel), int'(cur_sel));
        end
    end

    initial begin
        rst_n = 1'b0;
        sw    = 2'd0;
        key   = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(100);

        // Switch load, then back to 0
        sw = 2'd2; expect_sel(2'd2); tick(20);
        sw = 2'd0; expect_sel(2'd0); tick(20);

        // Four presses walk 1,2,3,0
        for (int i = 1; i <= 4; i++) begin
            key = 1'b0;
            expect_sel(2'(i));
            tick(10);
            key = 1'b1;
            tick(10);
        end

        // 3-cycle glitch is filtered
        key = 1'b0; tick(3);
        key = 1'b1; tick(20);

        // Press to 1, then switch to 1 rewrites same value without a pulse
        key = 1'b0; expect_sel(2'd1); tick(10);
        key = 1'b1; tick(10);
        sw  = 2'd1; tick(20);
        sw  = 2'd0; expect_sel(2'd0); tick(20);

        // Switch and press debounce together: switch wins
        sw = 2'd1; key = 1'b0; expect_sel(2'd1); tick(10);
        key = 1'b1; tick(20);

        // Reach sel=3, then reset while the press counter is at 2
        sw = 2'd3; expect_sel(2'd3); tick(20);
        key = 1'b0; tick(4);
        rst_n = 1'b0;
        #1;
        check("async_reset_sel", int'(sel), 0);
        check("async_reset_change", int'(sel_change), 0);
        tick(1);
        rst_n = 1'b1;
        // SW=3 and held key re-debounce together: one pulse to 3, press dropped
        expect_sel(2'd3);
        tick(20);
        key = 1'b1; tick(10);
        key = 1'b0; expect_sel(2'd0); tick(10);
        key = 1'b1; tick(20);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
